// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared state encoding and slice width for the nibble-serial subtractor
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/four_bit_subtr.sv
// rtl/four_bit_subtr.sv - 4-bit ripple-borrow subtractor cell, s = a - b - cin
module four_bit_subtr (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic [3:0] c
);

  // Borrow into each bit: external cin for bit 0, then the borrow out of the bit below.
  logic [3:0] w_bi;

  assign w_bi = {c[2:0], cin};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign s[gi] = a[gi] ^ b[gi] ^ w_bi[gi];
      assign c[gi] = (w_bi[gi] & ~(a[gi] ^ b[gi])) | (~a[gi] & b[gi]);
    end
  endgenerate

endmodule

// File: rtl/nibble_serial_subtr_ctrl.sv
// rtl/nibble_serial_subtr_ctrl.sv - sequencer computing a - b - bin one nibble per cycle, LSB nibble first
module nibble_serial_subtr_ctrl
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                    bin,
  output logic                    busy,
  output logic                    done,
  output logic [NIBBLE_W*NIBBLES-1:0] diff,
  output logic                    bout,
  output logic                    zero,
  output logic                    ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t          r_state;
  logic [W-1:0]    r_a_sh;
  logic [W-1:0]    r_b_sh;
  logic [W-1:0]    r_res_sh;
  logic            r_brw;
  logic [IW-1:0]   r_idx;
  logic            r_a_msb;
  logic            r_b_msb;

  logic [3:0]      w_s;
  logic [3:0]      w_c;
  logic [W-1:0]    w_res_next;

  four_bit_subtr u_cell (
    .a   (r_a_sh[3:0]),
    .b   (r_b_sh[3:0]),
    .cin (r_brw),
    .s   (w_s),
    .c   (w_c)
  );

  // New nibble enters from the top so that after NIBBLES shifts the result is aligned.
  generate
    if (NIBBLES == 1) begin : g_single
      assign w_res_next = w_s;
    end else begin : g_multi
      assign w_res_next = {w_s, r_res_sh[W-1:NIBBLE_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_brw    <= 1'b0;
      r_idx    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_brw   <= bin;
            r_a_msb <= a[W-1];
            r_b_msb <= b[W-1];
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res_sh <= w_res_next;
          r_brw    <= w_c[3];
          r_a_sh   <= r_a_sh >> NIBBLE_W;
          r_b_sh   <= r_b_sh >> NIBBLE_W;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            diff    <= w_res_next;
            bout    <= w_c[3];
            zero    <= (w_res_next == '0);
            ovf     <= (r_a_msb != r_b_msb) && (w_res_next[W-1] != r_a_msb);
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
